// File: rtl/part_2_pkg.sv
// Shared types for the partition-2 edge-capture feeder: joined channel
// vector, queued capture entry and the output-side state encoding.
package part_2_pkg;

    localparam int N_CH   = 3;
    localparam int DATA_W = 8;
    localparam int VW     = DATA_W + 1;
    localparam int SEQ_W  = 16;

    // One channel as presented to the initiator: {wen, data}.
    typedef logic [VW-1:0]      chan_vec_t;

    // All channels joined, channel k at bits [k*VW +: VW].
    typedef logic [N_CH*VW-1:0] joined_vec_t;

    typedef struct packed {
        joined_vec_t      vec;
        logic [SEQ_W-1:0] seq;
    } capture_entry_t;

    // Output-side state constants, kept as plain vectors for older code.
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HAVE  = 1'b1;

    typedef enum logic [0:0] {
        OUT_EMPTY = S_EMPTY,
        OUT_HAVE  = S_HAVE
    } out_state_e;

endpackage

// File: rtl/part_2_sync_fifo.sv
// Single-clock FIFO of capture entries with a registered head.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OUT_EMPTY | nothing queued, valid_o low, head_o holds last/reset value
// OUT_HAVE  | at least one entry queued, head_o is the oldest entry
//
// The head register is loaded on the same edge that changes the queue, so
// a freshly pushed entry shows up one cycle after the push and the next
// entry shows up one cycle after a pop. No bypass from wdata_i to head_o.
module part_2_sync_fifo
    import part_2_pkg::*;
#(
    parameter type entry_t = capture_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  entry_t                   wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output entry_t                   head_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          head_q;
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [AW-1:0]   rd_next_idx;
    out_state_e      state_q;
    out_state_e      state_d;
    logic            do_pop;
    logic            do_push;

    assign valid_o     = (state_q == OUT_HAVE);
    assign head_o      = head_q;
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop      = pop_i & valid_o;
    // A full queue still takes a push when the head leaves on the same edge.
    assign do_push     = push_i & (~full_o | do_pop);
    assign rd_next_idx = rd_ptr_q[AW-1:0] + 1'b1;

    // Output-side state: becomes HAVE on any push, EMPTY once the last entry leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (do_push) state_d = OUT_HAVE;
            OUT_HAVE:  if (do_pop && !do_push && (count_o == CW'(1))) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    // State register and read/write pointers; pointers wrap through the extra MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OUT_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Head register: next stored entry on a pop, incoming entry when the queue runs dry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
        end else if (do_pop) begin
            if (count_o > CW'(1)) begin
                head_q <= mem_q[rd_next_idx];
            end else if (do_push) begin
                head_q <= wdata_i;
            end
        end else if ((state_q == OUT_EMPTY) && do_push) begin
            head_q <= wdata_i;
        end
    end

endmodule

// File: rtl/part_2_edge_capture_q.sv
// Partition-2 edge capture queue: watches the selected mission clock as a
// data signal, snapshots the exported {wen, data} channels on each rising
// edge, tags each snapshot with a sequence number and queues it for the
// initiator. Requests a mission-clock freeze before the queue overflows.
module part_2_edge_capture_q
    import part_2_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SEQ_W       = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clk_h_i,
    input  logic                          freeze_i,
    input  logic [N_CH-1:0]               wen_i,
    input  logic [N_CH*DATA_W-1:0]        data_i,
    output logic                          vec_valid_o,
    input  logic                          vec_ready_i,
    output logic [N_CH*(DATA_W+1)-1:0]    vec_data_o,
    output logic [SEQ_W-1:0]              vec_seq_o,
    output logic                          freeze_req_o,
    output logic                          overflow_o,
    output logic [7:0]                    spurious_cnt_o
);

    localparam int CH_W = DATA_W + 1;
    localparam int CW   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [N_CH*CH_W-1:0] vec;
        logic [SEQ_W-1:0]     seq;
    } cap_entry_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   level_d_q;
    logic                   armed_q;
    logic                   level_s;
    logic                   cap_edge;
    logic                   live_edge;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [N_CH*CH_W-1:0]   joined;
    cap_entry_t             wr_entry;
    cap_entry_t             head;
    logic                   fifo_full;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          count_next;
    logic [SEQ_W-1:0]       seq_q;
    logic                   freeze_req_q;
    logic                   overflow_q;
    logic [7:0]             spur_q;

    // Channel inputs are sampled raw on the capture cycle; the producer keeps
    // them stable across the mission clock edge.
    for (genvar k = 0; k < N_CH; k++) begin : g_join
        assign joined[k*CH_W +: CH_W] = {wen_i[k], data_i[k*DATA_W +: DATA_W]};
    end

    assign level_s   = sync_q[SYNC_STAGES-1];
    // armed_q blocks the edge that reset-cleared sync zeros would otherwise
    // fake when the mission clock is already high at reset release.
    assign cap_edge  = level_s & ~level_d_q & armed_q;
    assign live_edge = cap_edge & ~freeze_i;
    assign pop       = vec_valid_o & vec_ready_i;
    assign push      = live_edge & (~fifo_full | pop);
    assign drop      = live_edge & fifo_full & ~pop;
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    assign wr_entry.vec = joined;
    assign wr_entry.seq = seq_q;

    // Synchronizer chain plus a parallel marker of which stages hold real samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            level_d_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync_q[0]     <= clk_h_i;
            sync_vld_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i]     <= sync_q[i-1];
                sync_vld_q[i] <= sync_vld_q[i-1];
            end
            level_d_q <= level_s;
            if (sync_vld_q[SYNC_STAGES-1] && !level_s) armed_q <= 1'b1;
        end
    end

    // Sequence tag advances on every non-frozen edge, dropped or not, so drops leave a gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q <= '0;
        end else if (live_edge) begin
            seq_q <= seq_q + 1'b1;
        end
    end

    // Freeze request follows the post-update fill level; overflow and spurious count are status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freeze_req_q <= 1'b0;
            overflow_q   <= 1'b0;
            spur_q       <= '0;
        end else begin
            freeze_req_q <= (count_next >= CW'(DEPTH - 1));
            if (drop) overflow_q <= 1'b1;
            if (cap_edge && freeze_i && (spur_q != 8'hFF)) spur_q <= spur_q + 8'd1;
        end
    end

    part_2_sync_fifo #(
        .entry_t (cap_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (vec_ready_i),
        .valid_o (vec_valid_o),
        .head_o  (head),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign vec_data_o     = head.vec;
    assign vec_seq_o      = head.seq;
    assign freeze_req_o   = freeze_req_q;
    assign overflow_o     = overflow_q;
    assign spurious_cnt_o = spur_q;

endmodule

// File: tb/tb_part_2_edge_capture_q.sv
// Bench for the partition-2 edge capture queue: directed scenarios with
// literal expectations, then a long randomized run against a queue model.
module tb_part_2_edge_capture_q;

    localparam int N_CH   = 3;
    localparam int DATA_W = 8;
    localparam int VW     = DATA_W + 1;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;
    localparam int SEQ_W  = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   clk_h_i = 1'b0;
    logic                   freeze_i = 1'b0;
    logic [N_CH-1:0]        wen_i = '0;
    logic [N_CH*DATA_W-1:0] data_i = '0;
    logic                   vec_ready_i = 1'b0;
    logic                   vec_valid_o;
    logic [N_CH*VW-1:0]     vec_data_o;
    logic [SEQ_W-1:0]       vec_seq_o;
    logic                   freeze_req_o;
    logic                   overflow_o;
    logic [7:0]             spurious_cnt_o;

    part_2_edge_capture_q #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .SEQ_W(SEQ_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clk_h_i        (clk_h_i),
        .freeze_i       (freeze_i),
        .wen_i          (wen_i),
        .data_i         (data_i),
        .vec_valid_o    (vec_valid_o),
        .vec_ready_i    (vec_ready_i),
        .vec_data_o     (vec_data_o),
        .vec_seq_o      (vec_seq_o),
        .freeze_req_o   (freeze_req_o),
        .overflow_o     (overflow_o),
        .spurious_cnt_o (spurious_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [N_CH*VW-1:0] vec;
        logic [SEQ_W-1:0]   seq;
    } ent_t;

    ent_t             mq[$];
    bit               hq[$];      // clk_h_i as sampled on each posedge since reset
    logic [SEQ_W-1:0] m_seq;
    int               m_spur;
    bit               m_ovf;
    bit               m_freq;
    int               m_drops;

    function automatic logic [N_CH*VW-1:0] join_vec(input logic [N_CH-1:0] w, input logic [N_CH*DATA_W-1:0] d);
        logic [N_CH*VW-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*VW +: VW] = {w[k], d[k*DATA_W +: DATA_W]};
        return v;
    endfunction

    // A capture happens SYNC cycles after a 0->1 step in the sampled mission
    // clock, provided both samples were taken after reset.
    initial begin : model
        int  k;
        bit  e;
        bit  p;
        ent_t ne;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                mq.delete(); hq.delete();
                m_seq = '0; m_spur = 0; m_ovf = 0; m_freq = 0; m_drops = 0;
            end else begin
                k = hq.size();
                e = (k >= SYNC + 1) && hq[k-SYNC] && !hq[k-SYNC-1];
                hq.push_back(clk_h_i);
                p = (mq.size() != 0) && vec_ready_i;
                if (p) void'(mq.pop_front());
                if (e) begin
                    if (freeze_i) begin
                        if (m_spur < 255) m_spur++;
                    end else begin
                        if (mq.size() < DEPTH) begin
                            ne.vec = join_vec(wen_i, data_i);
                            ne.seq = m_seq;
                            mq.push_back(ne);
                        end else begin
                            m_ovf = 1; m_drops++;
                        end
                        m_seq = m_seq + 1'b1;
                    end
                end
                m_freq = (mq.size() >= DEPTH - 1);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                check("valid", vec_valid_o, mq.size() != 0);
                if (mq.size() != 0) begin
                    check("data", vec_data_o, mq[0].vec);
                    check("seq", vec_seq_o, mq[0].seq);
                end
                check("freeze_req", freeze_req_o, m_freq);
                check("overflow", overflow_o, m_ovf);
                check("spurious", spurious_cnt_o, m_spur);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    bit               rnd_ready = 0;
    int               ready_bias = 50;
    bit               mon_en = 0;
    bit               have_last = 0;
    logic [SEQ_W-1:0] last_seq;
    int               gaps = 0;
    int               pops = 0;

    task automatic step();
        if (rnd_ready) vec_ready_i = ($urandom_range(0, 99) < ready_bias);
        if (mon_en && vec_valid_o && vec_ready_i) begin
            if (have_last) begin
                check("seq_order", vec_seq_o > last_seq, 1'b1);
                gaps += int'(vec_seq_o - last_seq) - 1;
            end else begin
                gaps += int'(vec_seq_o);
            end
            have_last = 1; last_seq = vec_seq_o; pops++;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; clk_h_i = 1'b0; freeze_i = 1'b0; vec_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic pulse(input int hi, input int lo);
        clk_h_i = 1'b1;
        repeat (hi) step();
        clk_h_i = 1'b0;
        repeat (lo) step();
    endtask

    // One mission-clock period; records outputs just before and just after the capture cycle.
    task automatic pulse_obs(input int hi, input int lo, output logic v_b, output logic f_b,
                             output logic v_a, output logic f_a,
                             output logic [SEQ_W-1:0] s_a, output logic [N_CH*VW-1:0] d_a);
        clk_h_i = 1'b1;
        repeat (SYNC) @(negedge clk_i);
        v_b = vec_valid_o; f_b = freeze_req_o;
        @(negedge clk_i);
        v_a = vec_valid_o; f_a = freeze_req_o; s_a = vec_seq_o; d_a = vec_data_o;
        repeat (hi - SYNC - 1) @(negedge clk_i);
        clk_h_i = 1'b0;
        repeat (lo) @(negedge clk_i);
    endtask

    task automatic drain_expect(input string name, input int first, input int n);
        vec_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(name, vec_seq_o, SEQ_W'(first + i));
            @(negedge clk_i);
        end
        check({name, "_empty"}, vec_valid_o, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    logic               vb, fb, va, fa;
    logic [SEQ_W-1:0]   sa;
    logic [N_CH*VW-1:0] da;

    initial begin : main
        // Reset values
        #3;
        check("rst_valid", vec_valid_o, 1'b0);
        check("rst_data", vec_data_o, '0);
        check("rst_seq", vec_seq_o, '0);
        check("rst_freeze_req", freeze_req_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        check("rst_spurious", spurious_cnt_o, 8'd0);

        // 1: steady stream, always ready
        do_reset();
        wen_i = 3'b001; data_i = 24'h0000A5; vec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_obs(8, 8, vb, fb, va, fa, sa, da);
            check("t1_valid_before_c", vb, 1'b0);
            check("t1_valid_after_c", va, 1'b1);
            check("t1_seq", sa, SEQ_W'(i));
            check("t1_ch0", da[8:0], 9'h1A5);
            check("t1_freeze_req", fa, 1'b0);
        end

        // 2: stalled initiator, fill and overflow
        do_reset();
        wen_i = 3'b111; data_i = 24'h3C5A96;
        for (int i = 0; i < 5; i++) begin
            pulse_obs(8, 8, vb, fb, va, fa, sa, da);
            if (i == 2) begin
                check("t2_freeze_req_before_3rd", fb, 1'b0);
                check("t2_freeze_req_after_3rd", fa, 1'b1);
            end
        end
        check("t2_overflow", overflow_o, 1'b1);
        check("t2_head_seq", vec_seq_o, 16'd0);
        drain_expect("t2_pop_seq", 0, 4);
        pulse_obs(8, 8, vb, fb, va, fa, sa, da);
        check("t2_next_valid", va, 1'b1);
        check("t2_next_seq", sa, 16'd5);
        check("t2_overflow_sticky", overflow_o, 1'b1);

        // 3: edges during freeze are spurious
        do_reset();
        vec_ready_i = 1'b1; freeze_i = 1'b1;
        repeat (3) pulse(8, 8);
        freeze_i = 1'b0;
        check("t3_spurious", spurious_cnt_o, 8'd3);
        check("t3_valid", vec_valid_o, 1'b0);
        pulse_obs(8, 8, vb, fb, va, fa, sa, da);
        check("t3_seq_unchanged", sa, 16'd0);

        // 4: full FIFO, edge and pop on the same cycle
        do_reset();
        vec_ready_i = 1'b0;
        repeat (4) pulse(8, 8);
        check("t4_full_freeze_req", freeze_req_o, 1'b1);
        clk_h_i = 1'b1;
        repeat (SYNC) @(negedge clk_i);
        vec_ready_i = 1'b1;
        @(negedge clk_i);
        vec_ready_i = 1'b0;
        check("t4_overflow", overflow_o, 1'b0);
        check("t4_freeze_req", freeze_req_o, 1'b1);
        check("t4_head_seq", vec_seq_o, 16'd1);
        clk_h_i = 1'b0;
        repeat (4) @(negedge clk_i);
        drain_expect("t4_pop_seq", 1, 4);

        // 5: reset mid-stream with the mission clock high
        do_reset();
        repeat (2) pulse(8, 8);
        check("t5_pre_valid", vec_valid_o, 1'b1);
        clk_h_i = 1'b1;
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("t5_async_valid", vec_valid_o, 1'b0);
        check("t5_async_data", vec_data_o, '0);
        check("t5_async_seq", vec_seq_o, '0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        check("t5_no_edge_held_high", vec_valid_o, 1'b0);
        clk_h_i = 1'b0;
        repeat (6) @(negedge clk_i);
        pulse_obs(8, 8, vb, fb, va, fa, sa, da);
        check("t5_edge_after_low", va, 1'b1);
        check("t5_seq", sa, 16'd0);

        // 6: randomized run
        do_reset();
        rnd_ready = 1; mon_en = 1;
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_bias = 5;
                    1: ready_bias = 30;
                    2: ready_bias = 70;
                    default: ready_bias = 100;
                endcase
            end
            wen_i    = N_CH'($urandom());
            data_i   = (N_CH*DATA_W)'($urandom());
            freeze_i = ($urandom_range(0, 15) == 0);
            pulse($urandom_range(3, 9), $urandom_range(3, 9));
        end
        freeze_i = 1'b0;
        ready_bias = 100;
        repeat (DEPTH + 4) step();
        rnd_ready = 0; mon_en = 0;
        check("t6_drained", vec_valid_o, 1'b0);
        check("t6_gaps_equal_drops", gaps, m_drops);
        check("t6_pops_plus_drops", pops + m_drops, int'(m_seq));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
